// File: rtl/io_bus_pkg.sv
// Shared encodings for the AVR I/O register bus master: op codes, FSM states, widths and MCUCR layout.
package io_bus_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_PROT_WRITE = 2'b10,
    OP_RMW        = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_PW1    = 3'd3,
    ST_PW2    = 3'd4,
    ST_RMW_RD = 3'd5,
    ST_RMW_WR = 3'd6,
    ST_RSP    = 3'd7
  } state_e;

  // MCUCR location and bit positions on the I/O bus
  localparam logic [ADDR_W-1:0] MCUCR_ADDR = 6'h35;
  localparam int unsigned MCUCR_BODS  = 6;
  localparam int unsigned MCUCR_BODSE = 5;
  localparam int unsigned MCUCR_PUD   = 4;
  localparam int unsigned MCUCR_IVSEL = 1;
  localparam int unsigned MCUCR_IVCE  = 0;

  // Bits selected by mask take the new value, the rest keep the original
  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] orig,
                                                  input logic [DATA_W-1:0] mask,
                                                  input logic [DATA_W-1:0] bits);
    return (orig & ~mask) | (bits & mask);
  endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Command/response handshake plus I/O register bus signals seen by io_bus_master.
interface io_bus_master_if;
  import io_bus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] cmd_mask;

  logic [ADDR_W-1:0] IO_Addr;
  logic [DATA_W-1:0] dbus_out;
  logic [DATA_W-1:0] dbus_in;
  logic              out_en;
  logic              iore;
  logic              iowe;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    input  dbus_in, out_en, rsp_ready,
    output cmd_ready, IO_Addr, dbus_out, iore, iowe,
    output rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    output dbus_in, out_en, rsp_ready,
    input  cmd_ready, IO_Addr, dbus_out, iore, iowe,
    input  rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/io_bus_master.sv
// Initiator for the 6-bit AVR I/O bus: runs one READ/WRITE/PROT_WRITE/RMW command at a time.
// Optional macro IO_BUS_MASTER_RMW_EN enables read-modify-write; otherwise op 11 answers with an error.
module io_bus_master
  import io_bus_pkg::*;
(
  input  logic              cp2,
  input  logic              ireset,
  io_bus_master_if.master   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef IO_BUS_MASTER_RMW_EN
  logic [DATA_W-1:0] mask_q, mask_d;
`endif

  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] dbus_out_q, dbus_out_d;
  logic              iore_q, iore_d;
  logic              iowe_q, iowe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;

  assign accept = bus.cmd_valid && cmd_ready_q;

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
`ifdef IO_BUS_MASTER_RMW_EN
    mask_d      = mask_q;
`endif
    cmd_ready_d = 1'b0;
    io_addr_d   = '0;
    dbus_out_d  = '0;
    iore_d      = 1'b0;
    iowe_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = bus.cmd_addr;
          data_d = bus.cmd_data;
          case (bus.cmd_op)
            OP_READ: begin
              state_d   = ST_RD;
              iore_d    = 1'b1;
              io_addr_d = bus.cmd_addr;
            end
            OP_WRITE: begin
              state_d    = ST_WR;
              iowe_d     = 1'b1;
              io_addr_d  = bus.cmd_addr;
              dbus_out_d = bus.cmd_data;
            end
            OP_PROT_WRITE: begin
              // enable value goes first, the protected value follows next cycle
              state_d    = ST_PW1;
              iowe_d     = 1'b1;
              io_addr_d  = bus.cmd_addr;
              dbus_out_d = bus.cmd_mask;
            end
            OP_RMW: begin
`ifdef IO_BUS_MASTER_RMW_EN
              state_d   = ST_RMW_RD;
              mask_d    = bus.cmd_mask;
              iore_d    = 1'b1;
              io_addr_d = bus.cmd_addr;
`else
              state_d     = ST_RSP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      ST_RD: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ~bus.out_en;
        rsp_data_d  = bus.out_en ? bus.dbus_in : '0;
      end

      ST_WR: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
      end

      ST_PW1: begin
        state_d    = ST_PW2;
        iowe_d     = 1'b1;
        io_addr_d  = addr_q;
        dbus_out_d = data_q;
      end

      ST_PW2: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
      end

`ifdef IO_BUS_MASTER_RMW_EN
      ST_RMW_RD: begin
        rsp_data_d = bus.out_en ? bus.dbus_in : '0;
        if (!bus.out_en) begin
          // nobody owns the address: report it and skip the write-back
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          state_d    = ST_RMW_WR;
          rsp_err_d  = 1'b0;
          iowe_d     = 1'b1;
          io_addr_d  = addr_q;
          dbus_out_d = rmw_merge(bus.dbus_in, mask_q, data_q);
        end
      end

      ST_RMW_WR: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
      end
`endif

      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State, command and output registers
  always_ff @(posedge cp2) begin
    if (ireset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
`ifdef IO_BUS_MASTER_RMW_EN
      mask_q      <= '0;
`endif
      cmd_ready_q <= 1'b1;
      io_addr_q   <= '0;
      dbus_out_q  <= '0;
      iore_q      <= 1'b0;
      iowe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef IO_BUS_MASTER_RMW_EN
      mask_q      <= mask_d;
`endif
      cmd_ready_q <= cmd_ready_d;
      io_addr_q   <= io_addr_d;
      dbus_out_q  <= dbus_out_d;
      iore_q      <= iore_d;
      iowe_q      <= iowe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.IO_Addr   = io_addr_q;
  assign bus.dbus_out  = dbus_out_q;
  assign bus.iore      = iore_q;
  assign bus.iowe      = iowe_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master driving a behavioural MCUCR at 0x35 with timed IVCE/IVSEL update.
module tb_io_bus_master;
  import io_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_bus_master_if bus();

  io_bus_master dut (
    .cp2   (clk),
    .ireset(rst),
    .bus   (bus.master)
  );

  // MCUCR peripheral: IVSEL only changes within 4 cycles of writing IVCE=1
  logic [7:0] mcucr_q;
  int         ivce_cnt;

  assign bus.out_en  = bus.iore && (bus.IO_Addr == MCUCR_ADDR);
  assign bus.dbus_in = bus.out_en ? mcucr_q : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      mcucr_q  <= 8'h00;
      ivce_cnt <= 0;
    end else if (bus.iowe && bus.IO_Addr == MCUCR_ADDR) begin
      if (ivce_cnt != 0) begin
        mcucr_q  <= {bus.dbus_out[7:2], bus.dbus_out[MCUCR_IVSEL], 1'b0};
        ivce_cnt <= 0;
      end else begin
        mcucr_q  <= {bus.dbus_out[7:2], mcucr_q[MCUCR_IVSEL], bus.dbus_out[MCUCR_IVCE]};
        ivce_cnt <= bus.dbus_out[MCUCR_IVCE] ? 4 : 0;
      end
    end else if (ivce_cnt != 0) begin
      ivce_cnt <= ivce_cnt - 1;
      if (ivce_cnt == 1) mcucr_q[MCUCR_IVCE] <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  logic [7:0] wr_log[$];

  // Strobe bookkeeping and response scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.iore) rd_cnt++;
    if (bus.iowe) begin
      wr_cnt++;
      wr_log.push_back(bus.dbus_out);
    end
    if (bus.iore && bus.iowe) check("strobe_excl", 32'(bus.iore & bus.iowe), 0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (!bus.cmd_ready) check("accept_timeout", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 6'($urandom);
    bus.cmd_data  = 8'($urandom);
    bus.cmd_mask  = 8'($urandom);
  endtask

  task automatic offer(input op_e op, input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_mask  = m;
  endtask

  task automatic send(input op_e op, input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
    @(posedge clk);
    #1;
    offer(op, a, d, m);
    wait_accept();
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) check("rsp_timeout", 32'(sb.size()), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_iore"}, 32'(bus.iore), 0);
    check({tag, "_iowe"}, 32'(bus.iowe), 0);
    check({tag, "_addr"}, 32'(bus.IO_Addr), 0);
    check({tag, "_dout"}, 32'(bus.dbus_out), 0);
    check({tag, "_rvalid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rdata"}, 32'(bus.rsp_data), 0);
    check({tag, "_rerr"}, 32'(bus.rsp_err), 0);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 1);
  endtask

  int w0, r0, l0;

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_READ;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_mask  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // WRITE sets PUD
    push(8'h00, 1'b0);
    w0 = wr_cnt;
    send(OP_WRITE, 6'h35, 8'h10, 8'hff);
    @(negedge clk);
    check("wr_iowe", 32'(bus.iowe), 1);
    check("wr_iore", 32'(bus.iore), 0);
    check("wr_addr", 32'(bus.IO_Addr), 'h35);
    check("wr_dout", 32'(bus.dbus_out), 'h10);
    check("wr_rvalid_early", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    check("wr_iowe_off", 32'(bus.iowe), 0);
    check("wr_rvalid", 32'(bus.rsp_valid), 1);
    check("wr_addr_idle", 32'(bus.IO_Addr), 0);
    wait_rsp();
    check("wr_pud", 32'(mcucr_q[MCUCR_PUD]), 1);
    check("wr_count", 32'(wr_cnt - w0), 1);

    // READ back and read of an unmapped address
    push(8'h10, 1'b0);
    r0 = rd_cnt;
    send(OP_READ, 6'h35, 8'h00, 8'h00);
    @(negedge clk);
    check("rd_iore", 32'(bus.iore), 1);
    check("rd_addr", 32'(bus.IO_Addr), 'h35);
    @(negedge clk);
    check("rd_iore_off", 32'(bus.iore), 0);
    check("rd_rvalid", 32'(bus.rsp_valid), 1);
    wait_rsp();
    push(8'h00, 1'b1);
    send(OP_READ, 6'h20, 8'h00, 8'h00);
    wait_rsp();
    check("rd_count", 32'(rd_cnt - r0), 2);

    // Read-modify-write
    r0 = rd_cnt;
    w0 = wr_cnt;
`ifdef IO_BUS_MASTER_RMW_EN
    push(8'h10, 1'b0);
    send(OP_RMW, 6'h35, 8'h40, 8'h40);
    @(negedge clk);
    check("rmw_iore", 32'(bus.iore), 1);
    @(negedge clk);
    check("rmw_iowe", 32'(bus.iowe), 1);
    check("rmw_dout", 32'(bus.dbus_out), 'h50);
    check("rmw_iore_off", 32'(bus.iore), 0);
    @(negedge clk);
    check("rmw_rvalid", 32'(bus.rsp_valid), 1);
    wait_rsp();
    check("rmw_reg", 32'(mcucr_q), 'h50);
    check("rmw_wcount", 32'(wr_cnt - w0), 1);
    push(8'h00, 1'b1);
    w0 = wr_cnt;
    send(OP_RMW, 6'h20, 8'hff, 8'hff);
    wait_rsp();
    check("rmw_unmapped_nowrite", 32'(wr_cnt - w0), 0);
`else
    push(8'h00, 1'b1);
    send(OP_RMW, 6'h35, 8'h40, 8'h40);
    @(negedge clk);
    check("rmw_off_rvalid", 32'(bus.rsp_valid), 1);
    check("rmw_off_iore", 32'(bus.iore), 0);
    wait_rsp();
    check("rmw_off_rcount", 32'(rd_cnt - r0), 0);
    check("rmw_off_wcount", 32'(wr_cnt - w0), 0);
    check("rmw_off_reg", 32'(mcucr_q), 'h10);
`endif

    push(8'h00, 1'b0);
    send(OP_WRITE, 6'h35, 8'h10, 8'h00);
    wait_rsp();

    // Response back-pressure with a second command already offered
    bus.rsp_ready = 1'b0;
    push(8'h00, 1'b0);
    send(OP_WRITE, 6'h35, 8'h10, 8'h00);
    @(negedge clk);
    check("bp_iowe", 32'(bus.iowe), 1);
    @(negedge clk);
    check("bp_rvalid", 32'(bus.rsp_valid), 1);
    w0 = wr_cnt;
    r0 = rd_cnt;
    @(posedge clk);
    #1;
    push(8'h10, 1'b0);
    offer(OP_READ, 6'h35, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.rsp_valid), 1);
      check("bp_hold_data", 32'(bus.rsp_data), 0);
      check("bp_hold_ready", 32'(bus.cmd_ready), 0);
    end
    check("bp_no_wr", 32'(wr_cnt - w0), 0);
    check("bp_no_rd", 32'(rd_cnt - r0), 0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    check("bp_next_iore", 32'(bus.iore), 1);
    wait_rsp();

    // Timed two-step write: IVCE then IVSEL
    push(8'h00, 1'b0);
    l0 = wr_log.size();
    send(OP_PROT_WRITE, 6'h35, 8'h02, 8'h01);
    @(negedge clk);
    check("pw1_iowe", 32'(bus.iowe), 1);
    check("pw1_dout", 32'(bus.dbus_out), 'h01);
    @(negedge clk);
    check("pw2_iowe", 32'(bus.iowe), 1);
    check("pw2_dout", 32'(bus.dbus_out), 'h02);
    check("pw2_addr", 32'(bus.IO_Addr), 'h35);
    @(negedge clk);
    check("pw_iowe_off", 32'(bus.iowe), 0);
    check("pw_rvalid", 32'(bus.rsp_valid), 1);
    wait_rsp();
    check("pw_ivsel", 32'(mcucr_q[MCUCR_IVSEL]), 1);
    check("pw_ivce", 32'(mcucr_q[MCUCR_IVCE]), 0);
    check("pw_nwrites", 32'(wr_log.size() - l0), 2);

    // Reset between PW1 and PW2 drops the command
    w0 = wr_cnt;
    send(OP_PROT_WRITE, 6'h35, 8'h02, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pw1_iowe", 32'(bus.iowe), 1);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_iowe", 32'(bus.iowe), 0);
      check("rst_no_rsp", 32'(bus.rsp_valid), 0);
    end
    check("rst_wcount", 32'(wr_cnt - w0), 1);
    check("sb_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
